// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe types, win-line table and glyph/geometry constants for the
// board keeper and any later display block that renders the same board.
package ttt_pkg;

    typedef enum logic [1:0] {EMPTY = 2'b00, MARK_X = 2'b01, MARK_O = 2'b10} cell_t;
    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    typedef logic [8:0][1:0]   board_t;
    typedef logic [15:0][15:0] pix_t;

    localparam int NUM_LINES = 8;

    // Rows 0-2, columns 0-2, main diagonal, anti-diagonal
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [0:3][3:0] X_GLYPH = '{4'b1001, 4'b0110, 4'b0110, 4'b1001};
    localparam logic [0:3][3:0] O_GLYPH = '{4'b0110, 4'b1001, 4'b1001, 4'b0110};

    localparam int ROW_BASE [3] = '{1, 6, 11};
    localparam int COL_BASE [3] = '{14, 9, 4};

    function automatic logic line_win(board_t b, logic [2:0] l);
        logic [1:0] a0, a1, a2;
        a0 = b[WIN_LINES[l][0]];
        a1 = b[WIN_LINES[l][1]];
        a2 = b[WIN_LINES[l][2]];
        return (a0 != EMPTY) && (a0 == a1) && (a1 == a2);
    endfunction

endpackage

// File: rtl/board_keeper_if.sv
// Cursor/place/restart requests into the board keeper and its rendered state out.
interface board_keeper_if;
    logic [3:0] cursor;
    logic       place;
    logic       restart;
    logic [15:0][15:0] RedPixels;
    logic       turn;
    logic [1:0] winner;
    logic       game_over;

    modport master (output cursor, place, restart,
                    input  RedPixels, turn, winner, game_over);
    modport slave  (input  cursor, place, restart,
                    output RedPixels, turn, winner, game_over);
endinterface

// File: rtl/board_keeper_mark_renderer.sv
// Combinational board-to-bitmap renderer: 4x4 X/O glyphs inside the 16x16 grid
// cells; grid rows/columns always stay 0. A set blank bit hides that cell.
module mark_renderer
    import ttt_pkg::*;
(
    input  board_t     board,
    input  logic [8:0] blank,
    output pix_t       pixels
);

    always_comb begin
        pixels = '0;
        for (int k = 0; k < 9; k++) begin
            if (!blank[4'(k)] && board[4'(k)] != EMPTY) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        pixels[4'(ROW_BASE[k / 3] + i)][4'(COL_BASE[k % 3] - j)] =
                            (board[4'(k)] == MARK_X) ? X_GLYPH[2'(i)][2'(3 - j)]
                                                     : O_GLYPH[2'(i)][2'(3 - j)];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_keeper.sv
// Tic-tac-toe board keeper: records X/O moves, detects win/draw, renders marks.
// Define BOARD_KEEPER_FLASH_EN to blink the winning line while the game is over.
module board_keeper
    import ttt_pkg::*;
#(
    parameter int FLASH_W = 24
) (
    input  logic clock,
    input  logic reset,
    board_keeper_if.slave bus
);

    state_t     state;
    board_t     board;
    logic [3:0] moves;
    logic       turn;
    logic [1:0] winner;
    logic       game_over;
    logic       place_q, restart_q;
    logic       place_ev, restart_ev;
    logic       occupied;
    logic       win_found;
    logic [1:0] win_mark;
    logic [8:0] blank;

    assign place_ev   = bus.place & ~place_q;
    assign restart_ev = bus.restart & ~restart_q;

    // Out-of-range cursors fall through as occupied, so they are never accepted.
    always_comb begin
        occupied = 1'b1;
        for (int k = 0; k < 9; k++)
            if (bus.cursor == 4'(k)) occupied = (board[4'(k)] != EMPTY);
    end

    always_comb begin
        win_found = 1'b0;
        win_mark  = EMPTY;
        for (int l = NUM_LINES - 1; l >= 0; l--) begin
            if (line_win(board, 3'(l))) begin
                win_found = 1'b1;
                win_mark  = board[WIN_LINES[l][0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PLAY;
            board     <= '0;
            moves     <= '0;
            turn      <= 1'b0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            place_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            place_q   <= bus.place;
            restart_q <= bus.restart;
            case (state)
                PLAY: begin
                    if (place_ev && !occupied) begin
                        board[bus.cursor] <= turn ? MARK_O : MARK_X;
                        turn              <= ~turn;
                        moves             <= moves + 4'd1;
                        state             <= CHECK;
                    end
                end
                CHECK: begin
                    if (win_found) begin
                        winner    <= win_mark;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (moves == 4'd9) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= PLAY;
                    end
                end
                OVER: begin
                    if (restart_ev) begin
                        board     <= '0;
                        moves     <= '0;
                        turn      <= 1'b0;
                        winner    <= 2'b00;
                        game_over <= 1'b0;
                        state     <= PLAY;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

`ifdef BOARD_KEEPER_FLASH_EN
    logic [FLASH_W-1:0] flash_cnt;

    always_ff @(posedge clock) begin
        if (reset || (state == OVER && restart_ev)) flash_cnt <= '0;
        else if (state == OVER)                     flash_cnt <= flash_cnt + FLASH_W'(1);
    end

    // Only the lowest-indexed winning line blinks; a draw has no line to blink.
    always_comb begin
        blank = '0;
        if (state == OVER && win_found && flash_cnt[FLASH_W-1]) begin
            for (int l = NUM_LINES - 1; l >= 0; l--) begin
                if (line_win(board, 3'(l))) begin
                    blank = '0;
                    for (int m = 0; m < 3; m++) blank[WIN_LINES[l][m]] = 1'b1;
                end
            end
        end
    end
`else
    assign blank = '0;
`endif

    mark_renderer u_render (
        .board  (board),
        .blank  (blank),
        .pixels (bus.RedPixels)
    );

    assign bus.turn      = turn;
    assign bus.winner    = winner;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_board_keeper.sv
// Scoreboard bench for board_keeper: a behavioural game model pushes expected
// snapshots, which are popped and compared against the DUT outputs.
module tb_board_keeper;

`ifdef BOARD_KEEPER_FLASH_EN
    localparam int FW = 4;
`else
    localparam int FW = 24;
`endif

    typedef logic [15:0][15:0] pix_t;
    typedef struct {
        pix_t       pix;
        logic       turn;
        logic [1:0] winner;
        logic       over;
    } snap_t;

    logic clock = 1'b0;
    logic reset;
    board_keeper_if bus ();

    board_keeper #(.FLASH_W(FW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    snap_t sb[$];

    // Behavioural game model
    int   mb[9];
    logic mturn;
    int   mmoves;
    logic mover;
    logic [1:0] mwin;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int xg[4] = '{9, 6, 6, 9};
    int og[4] = '{6, 9, 9, 6};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic pix_t model_pix();
        pix_t p = '0;
        for (int k = 0; k < 9; k++) begin
            if (mb[k] != 0) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        p[1 + 5 * (k / 3) + i][14 - 5 * (k % 3) - j] =
                            1'(((mb[k] == 1 ? xg[i] : og[i]) >> (3 - j)) & 1);
            end
        end
        return p;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 9; k++) mb[k] = 0;
        mturn = 1'b0; mmoves = 0; mover = 1'b0; mwin = 2'b00;
    endtask

    task automatic model_place(input int c);
        if (!mover && c <= 8 && mb[c] == 0) begin
            mb[c] = mturn ? 2 : 1;
            mturn = ~mturn;
            mmoves++;
            for (int l = 0; l < 8; l++)
                if (!mover && mb[lines[l][0]] != 0 && mb[lines[l][0]] == mb[lines[l][1]]
                    && mb[lines[l][1]] == mb[lines[l][2]]) begin
                    mover = 1'b1;
                    mwin  = 2'(mb[lines[l][0]]);
                end
            if (!mover && mmoves == 9) begin
                mover = 1'b1;
                mwin  = 2'b11;
            end
        end
    endtask

    task automatic expect_state();
        snap_t s;
        s.pix = model_pix(); s.turn = mturn; s.winner = mwin; s.over = mover;
        sb.push_back(s);
    endtask

    task automatic check_dut(input string tag);
        snap_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pix"},       bus.RedPixels, e.pix);
        chk({tag, ".turn"},      bus.turn,      e.turn);
        chk({tag, ".winner"},    bus.winner,    e.winner);
        chk({tag, ".game_over"}, bus.game_over, e.over);
    endtask

    task automatic step(input string tag);
        expect_state();
        check_dut(tag);
    endtask

    task automatic do_reset();
        bus.cursor = 4'd0; bus.place = 1'b0; bus.restart = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic press(input int c);
        bus.cursor = 4'(c);
        bus.place  = 1'b1;
        tick();
        bus.place  = 1'b0;
        tick(); tick();
        model_place(c);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        tick();
        if (mover) model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int blanks, steady;
        do_reset();
        step("reset");

        // Centre X, glyph placement, then rejected moves
        press(4);
        step("x_centre");
        chk("x_row6",  bus.RedPixels[6][9:6], 4'b1001);
        chk("x_row7",  bus.RedPixels[7][9:6], 4'b0110);
        chk("x_row5",  bus.RedPixels[5],      16'h0000);
        press(4);
        step("occupied_reject");
        press(12);
        step("range_reject");

        // Held place gives one mark only
        do_reset();
        bus.cursor = 4'd0;
        bus.place  = 1'b1;
        repeat (20) tick();
        bus.place  = 1'b0;
        tick();
        model_place(0);
        step("held_place");
        press(1);
        step("after_hold_o");

        // X wins row 0; restart ignored during play
        do_reset();
        press(0); press(3);
        pulse_restart();
        step("restart_in_play");
        press(1); press(4);
        bus.cursor = 4'd2;
        bus.place  = 1'b1;
        tick();
        chk("lat_accept_winner", bus.winner, 2'b00);
        chk("lat_accept_over",   bus.game_over, 1'b0);
        tick();
        bus.place = 1'b0;
        chk("lat_check_winner", bus.winner, 2'b01);
        chk("lat_check_over",   bus.game_over, 1'b1);
        tick();
        model_place(2);
        step("x_wins");
        press(8);
        step("over_place_ignored");

        blanks = 0; steady = 0;
        for (int n = 0; n < 16; n++) begin
            tick();
            if (bus.RedPixels[1][14:11] == 4'b0000 && bus.RedPixels[1][4:1] == 4'b0000) blanks++;
            if (bus.RedPixels[6][14:11] == 4'b0110 && bus.RedPixels[7][9:6] == 4'b1001) steady++;
        end
`ifdef BOARD_KEEPER_FLASH_EN
        chk("flash_blank_cycles", 32'(blanks), 32'd8);
`else
        chk("flash_blank_cycles", 32'(blanks), 32'd0);
`endif
        chk("o_marks_steady", 32'(steady), 32'd16);

        // Full board, no line: draw, then restart wins over simultaneous place
        do_reset();
        foreach (lines[0][i]) ; // no-op keeps foreach var local
        press(0); press(1); press(2); press(4); press(3);
        press(5); press(7); press(6);
        step("draw_pre");
        press(8);
        step("draw");
        bus.cursor  = 4'd0;
        bus.place   = 1'b1;
        bus.restart = 1'b1;
        tick();
        bus.place   = 1'b0;
        bus.restart = 1'b0;
        tick();
        model_clear();
        step("restart_clear");
        press(0);
        step("play_after_restart");

        // Reset mid-game
        press(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        step("reset_mid_game");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
